ksa_share_arbiter: RTL

- Time-shares one external 16-bit Kogge-Stone adder (combinational, no carry-in) among NREQ requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- A round-robin arbiter grants one request at a time and holds that request's operands stable on the adder for SETTLE_CYCLES.
- The block then registers {cout, sum} and returns it to the granted requester. It sits between the user-project requesters (LA/GPIO/Wishbone front ends) and the single adder instance.

---
 rtl/ksa_share_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ksa_share_arbiter.sv
// Round-robin time-sharing wrapper around one external combinational adder.
// Grants one requester, holds its operands on the adder for SETTLE_CYCLES, then returns {cout, sum}.
module ksa_share_arbiter #(
    parameter int WIDTH         = 16,
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [WIDTH-1:0]        resp_sum,
    output logic                    resp_cout,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_cout,
    output logic                    busy,
    output logic [31:0]             op_count
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gid;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;

    // Unpack the flat operand buses into per-requester lanes.
    logic [WIDTH-1:0] a_lane [NREQ];
    logic [WIDTH-1:0] b_lane [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign a_lane[i] = req_a[i*WIDTH +: WIDTH];
        assign b_lane[i] = req_b[i*WIDTH +: WIDTH];
    end

    // Rotate valids so bit 0 is the pointer position, then take the lowest set bit.
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW:0]      off;
    logic [IDW:0]      sel;
    logic [IDW-1:0]    pick;
    logic              any;

    assign dbl = {req_valid, req_valid} >> ptr;
    assign rot = dbl[NREQ-1:0];

    always_comb begin
        off = '0;
        any = 1'b0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (rot[k]) begin
                off = (IDW+1)'(k);
                any = 1'b1;
            end
        end
        sel = {1'b0, ptr} + off;
        if (sel >= (IDW+1)'(NREQ))
            sel = sel - (IDW+1)'(NREQ);
        pick = sel[IDW-1:0];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= IDLE;
            ptr      <= '0;
            gid      <= '0;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        op_a  <= a_lane[pick];
                        op_b  <= b_lane[pick];
                        gid   <= pick;
                        cnt   <= CW'(SETTLE_CYCLES - 1);
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == '0) begin
                        res_sum  <= add_sum;
                        res_cout <= add_cout;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready[gid]) begin
                        state    <= IDLE;
                        ptr      <= (gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1;
                        op_count <= op_count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operands come straight from registers so the adder inputs never glitch.
    assign add_a      = op_a;
    assign add_b      = op_b;
    assign resp_sum   = res_sum;
    assign resp_cout  = res_cout;
    assign busy       = (state != IDLE);
    assign req_ready  = (state == IDLE && any) ? (NREQ'(1) << pick) : '0;
    assign resp_valid = (state == RESP) ? (NREQ'(1) << gid) : '0;

endmodule
